// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller sharing one 3-bit SevenSeg decoder across NUM_DIGITS positions with blanking gaps.
// Optional per-digit dimming is compiled in when SEG_SCAN_DIM_EN is defined (adds the dim port).
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV         = 16,
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [1:0]              dim,
`endif
  input  logic                    load_valid,
  input  logic [3*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [2:0]              code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMAX = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int TW   = $clog2(TMAX);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int FW   = 3 * NUM_DIGITS;

  // IDLE: dark, prescaler held | BLANK: code settles, digits off | SHOW: digit idx lit
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   active_q, active_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            fdone_q, fdone_d;
  logic            tick;
  logic            boundary;
  logic            lit;
  logic [2:0]      code_cur;
`ifdef SEG_SCAN_DIM_EN
  logic [1:0]      dim_q, dim_d;
  int              dim_eff;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tcnt_q    <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      fdone_q   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      dim_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      fdone_q   <= fdone_d;
`ifdef SEG_SCAN_DIM_EN
      dim_q     <= dim_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    tick      = 1'b0;
    presc_d   = '0;
`ifdef SEG_SCAN_DIM_EN
    dim_d     = dim_q;
`endif
    if (state_q != S_IDLE && en) begin
      tick    = (presc_q == PW'(DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        idx_d  = '0;
        if (en) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!en) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          idx_d   = '0;
        end else if (tick) begin
          if (tcnt_q == TW'(BLANK_TICKS - 1)) begin
            state_d = S_SHOW;
            tcnt_d  = '0;
`ifdef SEG_SCAN_DIM_EN
            dim_d   = dim;
`endif
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (!en) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          idx_d   = '0;
        end else if (tick) begin
          if (tcnt_q == TW'(SHOW_TICKS - 1)) begin
            state_d = S_BLANK;
            tcnt_d  = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A swap needs pending set before this edge, so a load landing on the boundary waits a frame.
    if (pending_q && (boundary || state_q == S_IDLE)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (load_valid && !pending_q) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
    fdone_d = boundary;
  end

`ifdef SEG_SCAN_DIM_EN
  always_comb begin
    dim_eff = (int'(dim_q) < SHOW_TICKS - 1) ? int'(dim_q) : SHOW_TICKS - 1;
    lit     = (state_q == S_SHOW) && (int'(tcnt_q) < SHOW_TICKS - dim_eff);
  end
`else
  assign lit = (state_q == S_SHOW);
`endif

  always_comb begin
    code_cur  = '0;
    digit_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        code_cur     = active_q[3*i +: 3];
        digit_sel[i] = lit;
      end
    end
  end

  assign code       = (state_q == S_IDLE) ? 3'b000 : code_cur;
  assign blank      = ~lit;
  assign frame_done = fdone_q;
  assign load_ready = ~pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: timeline model of the scan plus directed load/enable/reset scenarios.
module tb_seven_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int DV = 2;
  localparam int BT = 1;
  localparam int ST = 4;
  localparam int DP = (BT + ST) * DV;
  localparam int FP = N * DP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load_valid = 1'b0;
  logic [3*N-1:0] load_data = '0;
  logic          load_ready;
  logic [2:0]    code;
  logic [N-1:0]  digit_sel;
  logic          blank;
  logic          frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [1:0]    dim = 2'd0;
`endif

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DV), .BLANK_TICKS(BT), .SHOW_TICKS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef SEG_SCAN_DIM_EN
    .dim(dim),
`endif
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .code(code), .digit_sel(digit_sel), .blank(blank), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: position p counts cycles since the scan started; everything follows from p.
  bit            m_run = 0;
  int            m_p = 0;
  logic [3*N-1:0] m_active = '0, m_shadow = '0;
  bit            m_pending = 0, m_fd = 0;
  int            m_dim = 0;

  always @(posedge clk) begin
    bit bnd;
    if (!rst_n) begin
      m_run = 0; m_p = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_fd = 0; m_dim = 0;
    end else begin
      bnd = m_run && en && (m_p % FP == FP - 1);
      if (m_pending && (bnd || !m_run)) begin
        m_active = m_shadow; m_pending = 0;
      end else if (load_valid && !m_pending) begin
        m_shadow = load_data; m_pending = 1;
      end
      m_fd = bnd;
      if (!m_run) begin
        if (en) begin m_run = 1; m_p = 0; end
      end else if (!en) begin
        m_run = 0;
      end else begin
        m_p++;
`ifdef SEG_SCAN_DIM_EN
        if (m_p % DP == BT * DV) m_dim = int'(dim);
`endif
      end
    end
  end

  always @(negedge clk) begin
    int q, d, r, de;
    logic [2:0] e_code;
    logic [N-1:0] e_sel;
    logic e_blank;
    if (chk_on) begin
      e_code = '0; e_sel = '0; e_blank = 1'b1;
      if (m_run) begin
        q = m_p % FP; d = q / DP; r = q % DP;
        e_code = m_active[3*d +: 3];
        de = (m_dim < ST - 1) ? m_dim : ST - 1;
        if (r >= BT * DV && ((r - BT * DV) / DV) < ST - de) begin
          e_sel = N'(1) << d; e_blank = 1'b0;
        end
      end
      chk("code", 32'(code), 32'(e_code));
      chk("digit_sel", 32'(digit_sel), 32'(e_sel));
      chk("blank", 32'(blank), 32'(e_blank));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("load_ready", 32'(load_ready), 32'(!m_pending));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_sel(input logic [N-1:0] v, input string nm);
    int c = 0;
    do begin @(negedge clk); c++; end while (digit_sel !== v && c < 4 * FP);
    if (digit_sel !== v) chk({nm, "_timeout"}, 32'(digit_sel), 32'(v));
  endtask

  task automatic wait_fd(input string nm);
    int c = 0;
    do begin @(negedge clk); c++; end while (frame_done !== 1'b1 && c < 4 * FP);
    if (frame_done !== 1'b1) chk({nm, "_timeout"}, 32'(frame_done), 32'(1));
  endtask

  task automatic run_len(input logic [N-1:0] v, output int c);
    c = 0;
    while (digit_sel === v && c < 4 * FP) begin c++; @(negedge clk); end
  endtask

  localparam logic [3*N-1:0] L1 = 12'b111_110_101_100;
  localparam logic [3*N-1:0] L2 = {3'b000, 3'b001, 3'b010, 3'b011};
  localparam logic [3*N-1:0] L3 = 12'b101_101_101_101;
  localparam logic [3*N-1:0] L4 = {3'b110, 3'b111, 3'b001, 3'b010};

  initial begin
    logic [2:0] l1_codes [N];
    int c;
    l1_codes[0] = 3'b100; l1_codes[1] = 3'b101; l1_codes[2] = 3'b110; l1_codes[3] = 3'b111;

    step(); chk_on = 1;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", 32'(load_ready), 32'(1));
    chk("rst_blank", 32'(blank), 32'(1));
    chk("rst_digit_sel", 32'(digit_sel), 32'(0));
    chk("rst_code", 32'(code), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));

    // Free-running scan with no frame loaded
    step(); en = 1'b1;
    wait_sel(4'b0001, "first_show");
    run_len(4'b0001, c);
    chk("show_len", 32'(c), 32'(8));
    run_len(4'b0000, c);
    chk("blank_len", 32'(c), 32'(2));
    chk("second_digit", 32'(digit_sel), 32'(4'b0010));
    wait_fd("fd_a");
    c = 0;
    do begin @(negedge clk); c++; end while (frame_done !== 1'b1 && c < 4 * FP);
    chk("frame_period", 32'(c), 32'(40));

    // Drop enable during digit 2
    wait_sel(4'b0100, "digit2");
    step(); en = 1'b0;
    step();
    @(negedge clk);
    chk("en_drop_sel", 32'(digit_sel), 32'(0));
    chk("en_drop_blank", 32'(blank), 32'(1));
    chk("en_drop_fd", 32'(frame_done), 32'(0));
    repeat (5) step();
    en = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (digit_sel === '0 && c < 4 * FP);
    chk("restart_digit", 32'(digit_sel), 32'(4'b0001));

    // Load while idle
    step(); en = 1'b0;
    step(); step();
    load_data = L1; load_valid = 1'b1;
    step(); load_valid = 1'b0;
    @(negedge clk);
    chk("idle_load_busy", 32'(load_ready), 32'(0));
    step();
    @(negedge clk);
    chk("idle_swap_ready", 32'(load_ready), 32'(1));
    step(); en = 1'b1;
    for (int d = 0; d < N; d++) begin
      wait_sel(N'(1) << d, "l1_digit");
      chk("l1_code", 32'(code), 32'(l1_codes[d]));
    end

    // Load mid-frame, second offer while pending must be ignored
    wait_sel(4'b0010, "mid_frame");
    step(); load_data = L2; load_valid = 1'b1;
    step(); load_data = L3;
    @(negedge clk);
    chk("pending_ready", 32'(load_ready), 32'(0));
    step(); step(); load_valid = 1'b0;
    wait_sel(4'b0100, "old_frame_d2");
    chk("old_frame_code", 32'(code), 32'(3'b110));
    wait_fd("fd_b");
    wait_sel(4'b0001, "l2_d0");
    chk("l2_code_d0", 32'(code), 32'(3'b011));
    chk("l3_not_taken", 32'(load_ready), 32'(1));
    wait_sel(4'b0010, "l2_d1");
    chk("l2_code_d1", 32'(code), 32'(3'b010));

    // Load accepted on the boundary edge itself
    wait_sel(4'b1000, "last_digit");
    repeat (7) step();
    load_data = L4; load_valid = 1'b1;
    step(); load_valid = 1'b0;
    @(negedge clk);
    chk("bnd_fd", 32'(frame_done), 32'(1));
    chk("bnd_pending", 32'(load_ready), 32'(0));
    wait_sel(4'b0001, "bnd_d0");
    chk("bnd_not_swapped", 32'(code), 32'(3'b011));
    wait_fd("fd_c");
    wait_sel(4'b0001, "l4_d0");
    chk("l4_code_d0", 32'(code), 32'(3'b010));

`ifdef SEG_SCAN_DIM_EN
    c = 0;
    do begin @(negedge clk); c++; end while (digit_sel !== '0 && c < 4 * FP);
    step(); dim = 2'd2;
    c = 0;
    do begin @(negedge clk); c++; end while (digit_sel === '0 && c < 4 * FP);
    run_len(digit_sel, c);
    chk("dim_lit_len", 32'(c), 32'(4));
    run_len(4'b0000, c);
    chk("dim_dark_len", 32'(c), 32'(6));
    wait_fd("fd_dim_a");
    c = 0;
    do begin @(negedge clk); c++; end while (frame_done !== 1'b1 && c < 4 * FP);
    chk("dim_frame_period", 32'(c), 32'(40));
    step(); dim = 2'd0;
`endif

    // Reset mid-scan discards a pending frame
    wait_sel(4'b0100, "pre_reset");
    step(); load_data = L3; load_valid = 1'b1;
    step(); load_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_pending", 32'(load_ready), 32'(0));
    step(); rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_sel", 32'(digit_sel), 32'(0));
    chk("mid_rst_blank", 32'(blank), 32'(1));
    chk("mid_rst_code", 32'(code), 32'(0));
    chk("mid_rst_ready", 32'(load_ready), 32'(1));
    step(); rst_n = 1'b1;
    wait_sel(4'b0001, "post_rst_d0");
    chk("post_rst_code", 32'(code), 32'(0));

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
